// File: rtl/qrd_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : qrd_skew_feeder
// Brief    : Double-buffered H (+ optional identity) loader that drives the
//            diagonally skewed row lanes of the systolic QR core.
// Revision : 1.0
// ============================================================================
module qrd_skew_feeder #(
  parameter int N    = 4,
  parameter int W    = 14,
  parameter int FRAC = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           aug_en,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_data_r,
  input  logic [W-1:0]   s_data_i,
  input  logic           core_ready,
  output logic [N*W-1:0] row_r,
  output logic [N*W-1:0] row_i,
  output logic [N-2:0]   row_f,
  output logic           feed_busy,
  output logic           feed_done
);

  localparam int           NW  = (N > 1) ? $clog2(N) : 1;
  localparam int           LW  = $clog2(3 * N);
  localparam logic [W-1:0] ONE = W'(1 << FRAC);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FEED = 1'b1;

  logic [W-1:0]   mem_r_q [2][N][N];
  logic [W-1:0]   mem_i_q [2][N][N];
  logic [1:0]     full_q, full_d;
  logic [1:0]     aug_q;
  logic           wr_ptr_q;
  logic           rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]  wrow_q, wcol_q;
  logic [0:0]     state_q, state_d;
  logic [LW-1:0]  l_q, l_d;
  logic [N*W-1:0] row_r_q, row_r_d, row_i_q, row_i_d;
  logic [N-2:0]   row_f_q, row_f_d;
  logic           done_q, done_d;

  logic           w_accept, w_last_beat, w_free, w_cur_aug;
  logic [LW-1:0]  w_last_l;
  logic [N*W-1:0] w_step_r, w_step_i;
  logic [N-2:0]   w_step_f;

  assign s_ready     = !full_q[wr_ptr_q];
  assign w_accept    = s_valid && s_ready;
  assign w_last_beat = (wrow_q == NW'(N - 1)) && (wcol_q == NW'(N - 1));
  assign w_cur_aug   = aug_q[rd_ptr_q];
  assign w_last_l    = w_cur_aug ? LW'(3 * N - 2) : LW'(2 * N - 2);

  // Write side: row/column counters walk the current bank row-major
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      wrow_q   <= '0;
      wcol_q   <= '0;
      aug_q    <= '0;
    end else if (w_accept) begin
      if ((wrow_q == '0) && (wcol_q == '0)) begin
        aug_q[wr_ptr_q] <= aug_en;
      end
      if (wcol_q == NW'(N - 1)) begin
        wcol_q <= '0;
        if (wrow_q == NW'(N - 1)) begin
          wrow_q   <= '0;
          wr_ptr_q <= ~wr_ptr_q;
        end else begin
          wrow_q <= wrow_q + NW'(1);
        end
      end else begin
        wcol_q <= wcol_q + NW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      mem_r_q[wr_ptr_q][wrow_q][wcol_q] <= s_data_r;
      mem_i_q[wr_ptr_q][wrow_q][wcol_q] <= s_data_i;
    end
  end

  // Lane j sees column l-j; identity one for lane j lands at l = N + 2j
  always_comb begin
    w_step_r = '0;
    w_step_i = '0;
    w_step_f = '0;
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        if (l_q == LW'(j + k)) begin
          w_step_r[j*W +: W] = mem_r_q[rd_ptr_q][j][k];
          w_step_i[j*W +: W] = mem_i_q[rd_ptr_q][j][k];
        end
      end
      if (w_cur_aug && (l_q == LW'(N + 2 * j))) begin
        w_step_r[j*W +: W] = ONE;
      end
    end
    for (int j = 0; j < N - 1; j++) begin
      w_step_f[j] = (l_q == LW'(2 * j));
    end
  end

  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    rd_ptr_d = rd_ptr_q;
    row_r_d  = row_r_q;
    row_i_d  = row_i_q;
    row_f_d  = row_f_q;
    done_d   = 1'b0;
    w_free   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_ptr_q]) begin
          state_d = ST_FEED;
          if (core_ready) begin
            row_r_d = w_step_r;
            row_i_d = w_step_i;
            row_f_d = w_step_f;
            l_d     = l_q + LW'(1);
          end
        end else if (core_ready) begin
          row_r_d = '0;
          row_i_d = '0;
          row_f_d = '0;
        end
      end
      ST_FEED: begin
        if (core_ready) begin
          row_r_d = w_step_r;
          row_i_d = w_step_i;
          row_f_d = w_step_f;
          if (l_q == w_last_l) begin
            done_d   = 1'b1;
            w_free   = 1'b1;
            rd_ptr_d = ~rd_ptr_q;
            l_d      = '0;
            // Chain straight into the other bank when it is already loaded
            state_d  = full_q[~rd_ptr_q] ? ST_FEED : ST_IDLE;
          end else begin
            l_d = l_q + LW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (w_accept && w_last_beat) begin
      full_d[wr_ptr_q] = 1'b1;
    end
    if (w_free) begin
      full_d[rd_ptr_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      l_q      <= '0;
      rd_ptr_q <= 1'b0;
      full_q   <= '0;
      row_r_q  <= '0;
      row_i_q  <= '0;
      row_f_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      l_q      <= l_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      row_r_q  <= row_r_d;
      row_i_q  <= row_i_d;
      row_f_q  <= row_f_d;
      done_q   <= done_d;
    end
  end

  assign row_r     = row_r_q;
  assign row_i     = row_i_q;
  assign row_f     = row_f_q;
  assign feed_busy = (state_q == ST_FEED);
  assign feed_done = done_q;

endmodule
`default_nettype wire
